// File: rtl/event_packer_if.sv
`timescale 1ns/1ps
// Bus between the event packer, the tube hit-time recorders and the event FIFO write port.
// The master side is the packer itself; the slave side is its environment.
interface event_packer_if #(
  parameter int N_TUBES = 32
);
  logic                   scin_coin;
  logic [N_TUBES*8-1:0]   tube_data;
  logic                   fifo_full;
  logic [9:0]             fifo_wr_count;
  logic [15:0]            fifo_din;
  logic                   fifo_wr_en;
  logic                   clr;
  logic                   gate_en;
  logic                   busy;
  logic [15:0]            event_count;
  logic [15:0]            drop_count;

  modport master (
    input  scin_coin, tube_data, fifo_full, fifo_wr_count,
    output fifo_din, fifo_wr_en, clr, gate_en, busy, event_count, drop_count
  );

  modport slave (
    output scin_coin, tube_data, fifo_full, fifo_wr_count,
    input  fifo_din, fifo_wr_en, clr, gate_en, busy, event_count, drop_count
  );
endinterface

// File: rtl/event_packer.sv
`timescale 1ns/1ps
// Event packer: on a scintillator coincidence, waits out the drift window, checks FIFO
// headroom, writes one {time, tube_id} word per tube plus a 16'hFFFF trailer, then re-arms the tubes.
module event_packer #(
  parameter int N_TUBES       = 32,
  parameter int WINDOW_CYCLES = 256,
  parameter int CLR_CYCLES    = 11,
  parameter int FIFO_DEPTH    = 1024,
  parameter bit SKIP_ZERO     = 1'b0
) (
  input logic            clk50,
  input logic            rst_n,
  event_packer_if.master bus
);
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX = 5'(N_TUBES - 1);
  // Highest occupancy that still leaves room for every tube word plus the trailer.
  localparam logic [10:0]      MAX_OCC  = 11'(FIFO_DEPTH - 2 - N_TUBES);

  typedef enum logic [2:0] {IDLE, WINDOW, CHECK, WRITE, TRAILER, CLEAR} state_t;

  state_t           state;
  logic             sync1, sync2, sync3, trig;
  logic [WIN_W-1:0] win_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [4:0]       idx;
  logic [7:0]       tube_time [N_TUBES];
  logic [7:0]       cur_time;
  logic             room, skip_cur;
  logic [1:0]       drop_inc;
  logic [15:0]      din_r, event_cnt_r, drop_cnt_r;
  logic             wr_en_r, clr_r, gate_r, busy_r;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Word id encodes wire, layer (0=A, 1=B) and chamber 3/4 for the FIFO consumer.
  function automatic logic [7:0] tube_id(input logic [4:0] i);
    return {i[2:0], i[3], 4'd3 + {3'd0, i[4]}};
  endfunction

  for (genvar g = 0; g < N_TUBES; g++) begin : g_unpack
    assign tube_time[g] = bus.tube_data[8*g +: 8];
  end

  assign trig     = sync2 & ~sync3;
  assign cur_time = tube_time[idx];
  assign skip_cur = SKIP_ZERO && (cur_time == 8'd0);
  assign room     = ({1'b0, bus.fifo_wr_count} <= MAX_OCC);

  // Any trigger outside IDLE is discarded; a CHECK-stage overflow discards the event too.
  always_comb begin
    drop_inc = 2'd0;
    if (state != IDLE)
      drop_inc = {1'b0, trig} + ((state == CHECK && !room) ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      state       <= CLEAR;
      win_cnt     <= '0;
      clr_cnt     <= '0;
      idx         <= '0;
      din_r       <= 16'hFFFF;
      wr_en_r     <= 1'b0;
      clr_r       <= 1'b1;
      gate_r      <= 1'b0;
      busy_r      <= 1'b1;
      event_cnt_r <= '0;
      drop_cnt_r  <= '0;
    end else begin
      sync1      <= bus.scin_coin;
      sync2      <= sync1;
      sync3      <= sync2;
      drop_cnt_r <= sat_add(drop_cnt_r, drop_inc);
      wr_en_r    <= 1'b0;
      din_r      <= 16'hFFFF;

      case (state)
        IDLE: begin
          if (trig) begin
            state   <= WINDOW;
            win_cnt <= '0;
            gate_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        WINDOW: begin
          if (win_cnt == WIN_LAST) begin
            state  <= CHECK;
            gate_r <= 1'b0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (room) begin
            state <= WRITE;
            idx   <= '0;
          end else begin
            state   <= CLEAR;
            clr_cnt <= '0;
            clr_r   <= 1'b1;
          end
        end
        WRITE: begin
          din_r <= {cur_time, tube_id(idx)};
          // A skipped tube advances even while the FIFO is full since nothing is written.
          if (skip_cur || !bus.fifo_full) begin
            wr_en_r <= !skip_cur;
            if (idx == LAST_IDX) state <= TRAILER;
            else idx <= idx + 1'b1;
          end
        end
        TRAILER: begin
          if (!bus.fifo_full) begin
            wr_en_r     <= 1'b1;
            event_cnt_r <= sat_add(event_cnt_r, 2'd1);
            state       <= CLEAR;
            clr_cnt     <= '0;
            clr_r       <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state  <= IDLE;
            clr_r  <= 1'b0;
            busy_r <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          clr_r   <= 1'b1;
          busy_r  <= 1'b1;
          gate_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_din    = din_r;
  assign bus.fifo_wr_en  = wr_en_r;
  assign bus.clr         = clr_r;
  assign bus.gate_en     = gate_r;
  assign bus.busy        = busy_r;
  assign bus.event_count = event_cnt_r;
  assign bus.drop_count  = drop_cnt_r;
endmodule

// File: tb/tb_event_packer.sv
`timescale 1ns/1ps
// Scoreboard bench for event_packer: a plain-arithmetic event model pushes expected FIFO words,
// a negedge monitor pops and compares them; dut0 writes every tube, dut1 skips empty tubes.
module tb_event_packer;
  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk50 = ~clk50;

  event_packer_if #(.N_TUBES(32)) b0 ();
  event_packer_if #(.N_TUBES(32)) b1 ();

  event_packer #(.SKIP_ZERO(1'b0)) dut0 (.clk50(clk50), .rst_n(rst_n), .bus(b0));
  event_packer #(.SKIP_ZERO(1'b1)) dut1 (.clk50(clk50), .rst_n(rst_n), .bus(b1));

  logic         coin [2];
  logic [255:0] td   [2];
  logic         full [2];
  logic [9:0]   occ  [2];
  logic         wr_v [2], gate_v [2], clr_v [2], busy_v [2];
  logic [15:0]  din_v [2], ev_v [2], dr_v [2];

  assign b0.scin_coin = coin[0];  assign b1.scin_coin = coin[1];
  assign b0.tube_data = td[0];    assign b1.tube_data = td[1];
  assign b0.fifo_full = full[0];  assign b1.fifo_full = full[1];
  assign b0.fifo_wr_count = occ[0]; assign b1.fifo_wr_count = occ[1];
  assign wr_v[0] = b0.fifo_wr_en; assign wr_v[1] = b1.fifo_wr_en;
  assign gate_v[0] = b0.gate_en;  assign gate_v[1] = b1.gate_en;
  assign clr_v[0] = b0.clr;       assign clr_v[1] = b1.clr;
  assign busy_v[0] = b0.busy;     assign busy_v[1] = b1.busy;
  assign din_v[0] = b0.fifo_din;  assign din_v[1] = b1.fifo_din;
  assign ev_v[0] = b0.event_count; assign ev_v[1] = b1.event_count;
  assign dr_v[0] = b0.drop_count;  assign dr_v[1] = b1.drop_count;

  logic [15:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int exp_ev [2], exp_dr [2];
  int win_start [2], first_off [2], last_off [2], wr_cnt [2], clr_rise [2], clr_len [2];
  logic gate_prev [2], clr_prev [2];
  logic [7:0] tt [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference id from the chamber/layer/wire geometry of tube i.
  function automatic logic [7:0] tube_id(input int i);
    int chamber, layer, wire_n;
    chamber = 3 + i / 16;
    layer   = (i / 8) % 2;
    wire_n  = i % 8;
    return 8'(wire_n * 32 + layer * 16 + chamber);
  endfunction

  always @(posedge clk50) cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (wr_v[0] && wr_v[1]) fail_now("both_duts_writing", 1, 0);
    for (int d = 0; d < 2; d++) begin
      if (gate_v[d] && !gate_prev[d]) begin
        win_start[d] = cyc;
        wr_cnt[d]    = 0;
      end
      if (clr_v[d] && !clr_prev[d]) begin
        clr_rise[d] = cyc - win_start[d];
        clr_len[d]  = 0;
      end
      if (clr_v[d]) clr_len[d]++;
      gate_prev[d] = gate_v[d];
      clr_prev[d]  = clr_v[d];
      if (cyc > 2 && clr_v[d] && !wr_v[d]) check("clear_din", 32'(din_v[d]), 32'h0000FFFF);
      if (wr_v[d]) begin
        if (wr_cnt[d] == 0) first_off[d] = cyc - win_start[d];
        last_off[d] = cyc - win_start[d];
        wr_cnt[d]++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: dut%0d wrote 0x%04h, required no write", d, din_v[d]);
        end else begin
          check("fifo_din", 32'(din_v[d]), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    int n, busy_lo;
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    for (int d = 0; d < 2; d++) begin
      check("rst_clr", 32'(clr_v[d]), 32'd1);
      check("rst_busy", 32'(busy_v[d]), 32'd1);
      check("rst_wr_en", 32'(wr_v[d]), 32'd0);
      check("rst_gate", 32'(gate_v[d]), 32'd0);
      check("rst_din", 32'(din_v[d]), 32'h0000FFFF);
      check("rst_events", 32'(ev_v[d]), 32'd0);
      check("rst_drops", 32'(dr_v[d]), 32'd0);
    end
    rst_n   = 1'b1;
    n       = 0;
    busy_lo = 0;
    for (int k = 0; k < 40; k++) begin
      if (!clr_v[0]) break;
      if (!busy_v[0]) busy_lo++;
      n++;
      @(negedge clk50);
    end
    check("clr_cycles_after_reset", n, 11);
    check("busy_low_during_clear", busy_lo, 0);
    check("busy_after_clear", 32'(busy_v[0]), 32'd0);
  endtask

  task automatic wait_gate(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk50);
      ok = gate_v[d];
    end
    if (!ok) fail_now("gate_timeout", 0, 1);
  endtask

  // One trigger on dut d; ca = extra coin offset in the window (-1 none), cb = extra coin during CLEAR.
  task automatic run_event(input int d, input int occ_val, input int sidx, input int slen,
                           input int ca, input bit cb);
    bit accept, ok, done;
    int nwords, end_off, kb;
    accept  = (1023 - occ_val) >= 33;
    end_off = accept ? 290 + slen : 257;
    kb      = cb ? end_off + 2 : -1;
    nwords  = 0;
    occ[d]  = 10'(occ_val);
    for (int i = 0; i < 32; i++) td[d][8*i +: 8] = tt[i];
    if (accept) begin
      for (int i = 0; i < 32; i++)
        if (!(d == 1 && tt[i] == 8'd0)) begin
          exp_q.push_back({tt[i], tube_id(i)});
          nwords++;
        end
      exp_q.push_back(16'hFFFF);
      nwords++;
      exp_ev[d]++;
    end else begin
      exp_dr[d]++;
    end
    if (ca >= 0) exp_dr[d]++;
    if (cb) exp_dr[d]++;
    coin[d] = 1'b1;
    repeat (2) @(negedge clk50);
    coin[d] = 1'b0;
    wait_gate(d, ok);
    if (!ok) return;
    done = 1'b0;
    for (int k = 1; k <= 800 && !done; k++) begin
      @(negedge clk50);
      coin[d] = (ca >= 0 && k >= ca && k < ca + 2) || (kb >= 0 && k >= kb && k < kb + 2);
      full[d] = (slen > 0 && k >= 257 + sidx && k < 257 + sidx + slen);
      done    = !busy_v[d];
    end
    coin[d] = 1'b0;
    full[d] = 1'b0;
    if (!done) fail_now("event_timeout", 0, 1);
    check("words_outstanding", exp_q.size(), 0);
    check("event_count", 32'(ev_v[d]), exp_ev[d]);
    check("drop_count", 32'(dr_v[d]), exp_dr[d]);
    check("clr_offset", clr_rise[d], end_off);
    check("clr_length", clr_len[d], 11);
    if (accept) begin
      check("write_count", wr_cnt[d], nwords);
      check("last_write_offset", last_off[d], end_off);
      if (d == 0 || tt[0] != 8'd0) check("first_write_offset", first_off[d], 258);
    end else begin
      check("write_count_dropped", wr_cnt[d], 0);
    end
  endtask

  initial begin
    bit ok;
    int d, occ_val, sidx, slen, ca;
    bit cb;
    coin = '{1'b0, 1'b0};
    full = '{1'b0, 1'b0};
    occ  = '{10'd0, 10'd0};
    td   = '{256'd0, 256'd0};
    exp_ev = '{0, 0};
    exp_dr = '{0, 0};
    gate_prev = '{1'b0, 1'b0};
    clr_prev  = '{1'b0, 1'b0};
    win_start = '{0, 0};
    wr_cnt    = '{0, 0};

    do_reset();

    for (int i = 0; i < 32; i++) tt[i] = 8'(i + 1);
    run_event(0, 0, -1, 0, -1, 1'b0);
    run_event(0, 992, -1, 0, -1, 1'b0);
    run_event(0, 990, -1, 0, -1, 1'b0);
    run_event(0, 1000, -1, 0, 254, 1'b0);
    run_event(0, 0, 10, 5, -1, 1'b0);
    run_event(0, 0, -1, 0, 100, 1'b1);

    for (int i = 0; i < 32; i++) tt[i] = 8'd0;
    tt[0]  = 8'h5A;
    tt[31] = 8'hA5;
    run_event(1, 0, -1, 0, -1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      d = it % 2;
      for (int i = 0; i < 32; i++)
        tt[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      occ_val = $urandom_range(984, 996);
      slen    = (d == 0) ? $urandom_range(0, 4) : 0;
      sidx    = (slen > 0) ? $urandom_range(0, 31) : -1;
      ca      = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 240) : -1;
      cb      = 1'($urandom_range(0, 1));
      run_event(d, occ_val, sidx, slen, ca, cb);
    end

    // Reset in the middle of the tube writes abandons the event.
    for (int i = 0; i < 32; i++) tt[i] = 8'(i + 1);
    for (int i = 0; i < 32; i++) td[0][8*i +: 8] = tt[i];
    occ[0] = 10'd0;
    for (int i = 0; i < 32; i++) exp_q.push_back({tt[i], tube_id(i)});
    coin[0] = 1'b1;
    repeat (2) @(negedge clk50);
    coin[0] = 1'b0;
    wait_gate(0, ok);
    repeat (265) @(negedge clk50);
    @(posedge clk50);
    #5 rst_n = 1'b0;
    #1;
    check("midwrite_rst_wr_en", 32'(wr_v[0]), 32'd0);
    check("midwrite_rst_clr", 32'(clr_v[0]), 32'd1);
    check("midwrite_rst_busy", 32'(busy_v[0]), 32'd1);
    exp_q.delete();
    exp_ev = '{0, 0};
    exp_dr = '{0, 0};
    do_reset();
    run_event(0, 0, -1, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/event_packer.md
Name: event_packer

Overview:
- Sits directly upstream of the 16x1024 event FIFO, between the 32 Tube hit-time recorders and the FIFO write port.
- On a scintillator coincidence it waits a fixed drift window, checks FIFO space, and writes one {time, tube_id} word per tube plus an all-ones trailer.
- It then pulses the tubes' clear line to re-arm them.
- It replaces the free-running counter/case write scheme with an explicit FSM that has overflow protection and event/drop statistics.

Parameters:
N_TUBES, 32, number of tube channels scanned; tube index i maps to chamber 3+i[4], layer i[3] (0=A, 1=B), wire i[2:0].
WINDOW_CYCLES, 256, drift-window length in clk50 cycles between trigger and readout.
CLR_CYCLES, 11, length of the clr pulse to the Tube modules.
FIFO_DEPTH, 1024, FIFO capacity in words.
SKIP_ZERO, 0, if 1, tubes with time==0 (no hit) are not written.

Ports:
clk50  in  1  system clock (50 MHz, DCM-derived).
rst_n  in  1  asynchronous active-low reset.
scin_coin  in  1  raw scintillator coincidence; synchronized internally.
tube_data  in  N_TUBES*8  concatenated 8-bit hit times; tube i at [8i+7:8i].
fifo_full  in  1  FIFO full flag.
fifo_wr_count  in  10  FIFO write-side occupancy.
fifo_din  out  16  FIFO write data: [15:8]=time, [7:0]=tube id.
fifo_wr_en  out  1  FIFO write strobe.
clr  out  1  active-high clear to all Tube modules.
gate_en  out  1  tube recording enable (high during WINDOW).
busy  out  1  high in every state except IDLE.
event_count  out  16  events fully written; saturates at 16'hFFFF.
drop_count  out  16  triggers discarded; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n low):
  - state=CLEAR, clear counter=0, clr=1, busy=1.
  - fifo_wr_en=0, fifo_din=16'hFFFF, gate_en=0, both counters=0, synchronizer flops=0.
  - After rst_n rises, CLEAR runs its normal CLR_CYCLES cycles before IDLE.
- Trigger: scin_coin passes through a 2-flop synchronizer. A trigger is a rising edge at the synchronizer output (sync2 & ~sync3).
- All outputs are registered.
- IDLE: trigger -> WINDOW next cycle, window counter=0, gate_en=1.
- WINDOW:
  - Lasts exactly WINDOW_CYCLES cycles, then CHECK; gate_en drops on leaving.
  - Further triggers are ignored and increment drop_count.
- CHECK (1 cycle): free = FIFO_DEPTH-1-fifo_wr_count.
  - If free >= N_TUBES+1, go to WRITE with idx=0.
  - Otherwise drop the whole event: drop_count+1, go to CLEAR. Partial events are never written.
- WRITE (per cycle):
  - Drive fifo_din={tube_data[idx], id(idx)} where id={idx[2:0], idx[3], 4'd3+idx[4]}; e.g. idx0=0x03, idx1=0x23, idx8=0x13, idx16=0x04, idx31=0xF4.
  - fifo_wr_en=1 and idx+1, unless fifo_full: then wr_en=0 and idx holds (stall).
  - SKIP_ZERO=1 with time==0: wr_en=0 and idx still advances.
  - After idx N_TUBES-1 is written, go to TRAILER.
- TRAILER: write 16'hFFFF (stall on fifo_full as in WRITE); event_count+1; go to CLEAR.
- CLEAR: clr=1 for exactly CLR_CYCLES cycles, then IDLE with clr=0. Triggers seen during CLEAR increment drop_count.
- Timing: with no stalls or skips, wr_en is high for N_TUBES+1 consecutive cycles, the first beginning WINDOW_CYCLES+2 cycles after WINDOW entry. Frame length = WINDOW_CYCLES+1+N_TUBES+1+CLR_CYCLES cycles.
- fifo_wr_en is low outside WRITE/TRAILER, and fifo_din=16'hFFFF there.
- Counter rules:
  - Both counters saturate at 16'hFFFF.
  - A trigger in the same cycle as a drop in CHECK adds 2 to drop_count (saturating).
- tube_data is sampled live during WRITE. Tubes must hold their values until clr.

Test Plan:
- Reset with rst_n low for 3 cycles, release -> clr high for 11 cycles after release; busy=1 throughout, then 0; no wr_en pulse.
- Single scin_coin pulse, tube i data=i+1, empty FIFO -> 33 consecutive writes at cycles 258..290 after WINDOW entry: 0x0103, 0x0223, …, 0x20F4, then 0xFFFF. event_count=1, then clr for 11 cycles.
- fifo_wr_count=992 at CHECK -> no writes; drop_count=1; clr pulse still occurs. The same trigger at fifo_wr_count=990 -> full 33-word event.
- fifo_full forced high for 5 cycles mid-WRITE at idx=10 -> wr_en low for those 5 cycles, word 10 (0x??53) written once after release, no duplicates or gaps, 33 words total.
- SKIP_ZERO=1, only tubes 0 and 31 non-zero -> exactly 3 writes (tube0, tube31, 0xFFFF). CLEAR is entered at the same cycle offset as the no-skip case.
- Second coin pulse at WINDOW cycle 100, and a third during CLEAR -> one event written, drop_count=2. Asserting rst_n low mid-WRITE -> wr_en=0 immediately, and the post-reset clear sequence runs.
